memory_arbiter: RTL and testbench

Shared-RAM arbiter for the multicore processor. It sits between the per-CPU instruction and data cache ports and the single RAM port. It replaces the single-CPU combinational pass-through with a registered grant FSM. It serializes all instruction fetches, data loads and data stores onto the RAM, alternating between CPUs round-robin.

---
 rtl/cpu_types_pkg.sv | 23 ++
 rtl/memory_arbiter_rr_picker.sv | 32 +++
 rtl/memory_arbiter.sv | 115 +++++++++++
 tb/tb_memory_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU/memory-system types: word, RAM handshake state and the arbiter FSM state.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } arb_state_t;

  // Index wrap for a rotating pointer that never exceeds 2*n-1.
  function automatic int rr_wrap(input int idx, input int n);
    return (idx >= n) ? idx - n : idx;
  endfunction

endpackage

// File: rtl/memory_arbiter_rr_picker.sv
// Round-robin requester picker: rr_cpu first, then ascending with wrap; the D-port wins within a CPU.
module rr_picker #(
  parameter  int CPUS = 2,
  localparam int CW   = (CPUS > 1) ? $clog2(CPUS) : 1
) (
  input  logic [CPUS-1:0] req_i,
  input  logic [CPUS-1:0] req_d,
  input  logic [CW-1:0]   rr_cpu,
  output logic            grant_vld,
  output logic [CW-1:0]   grant_cpu,
  output logic            grant_is_d
);
  import cpu_types_pkg::*;

  logic [CW-1:0] cidx;

  always_comb begin
    grant_vld  = 1'b0;
    grant_cpu  = '0;
    grant_is_d = 1'b0;
    cidx       = '0;
    for (int k = 0; k < CPUS; k++) begin
      cidx = CW'(rr_wrap(int'(rr_cpu) + k, CPUS));
      if (!grant_vld && (req_d[cidx] || req_i[cidx])) begin
        grant_vld  = 1'b1;
        grant_cpu  = cidx;
        grant_is_d = req_d[cidx];
      end
    end
  end

endmodule

// File: rtl/memory_arbiter.sv
// Multicore shared-RAM arbiter: registered IDLE/XFER grant FSM serializing I-fetches, loads and stores.
module memory_arbiter
  import cpu_types_pkg::*;
#(
  parameter  int CPUS = 2,
  localparam int CW   = (CPUS > 1) ? $clog2(CPUS) : 1
) (
  input  logic                CLK,
  input  logic                nRST,
  input  logic [CPUS-1:0]     iREN,
  input  word_t [CPUS-1:0]    iaddr,
  input  logic [CPUS-1:0]     dREN,
  input  logic [CPUS-1:0]     dWEN,
  input  word_t [CPUS-1:0]    daddr,
  input  word_t [CPUS-1:0]    dstore,
  output logic [CPUS-1:0]     iwait,
  output logic [CPUS-1:0]     dwait,
  output word_t [CPUS-1:0]    iload,
  output word_t [CPUS-1:0]    dload,
  output logic                ramREN,
  output logic                ramWEN,
  output word_t               ramaddr,
  output word_t               ramstore,
  input  word_t               ramload,
  input  ramstate_t           ramstate
);

  arb_state_t      state;
  logic [CW-1:0]   rr_cpu;
  logic [CW-1:0]   grant_cpu;
  logic            grant_is_d;
  logic            grant_wen;
  word_t           grant_addr;
  word_t           grant_store;

  logic [CPUS-1:0] dreq;
  logic            pick_vld;
  logic [CW-1:0]   pick_cpu;
  logic            pick_is_d;
  logic            xfer;
  logic            still_req;
  logic            done;

  assign dreq = dREN | dWEN;

  rr_picker #(.CPUS(CPUS)) u_picker (
    .req_i      (iREN),
    .req_d      (dreq),
    .rr_cpu     (rr_cpu),
    .grant_vld  (pick_vld),
    .grant_cpu  (pick_cpu),
    .grant_is_d (pick_is_d)
  );

  // A granted requester that drops its enable mid-transfer aborts without completing.
  assign xfer      = (state == XFER);
  assign still_req = grant_is_d ? dreq[grant_cpu] : iREN[grant_cpu];
  assign done      = xfer && still_req && (ramstate == ACCESS);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state       <= IDLE;
      rr_cpu      <= '0;
      grant_cpu   <= '0;
      grant_is_d  <= 1'b0;
      grant_wen   <= 1'b0;
      grant_addr  <= '0;
      grant_store <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_vld) begin
            state       <= XFER;
            grant_cpu   <= pick_cpu;
            grant_is_d  <= pick_is_d;
            grant_addr  <= pick_is_d ? daddr[pick_cpu] : iaddr[pick_cpu];
            grant_store <= dstore[pick_cpu];
            grant_wen   <= pick_is_d & dWEN[pick_cpu];
          end
        end
        XFER: begin
          if (!still_req) begin
            state <= IDLE;
          end else if (ramstate == ACCESS) begin
            state  <= IDLE;
            rr_cpu <= CW'(rr_wrap(int'(grant_cpu) + 1, CPUS));
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // RAM drive and completion routing; BUSY/ERROR simply keep the same request on the bus.
  always_comb begin
    ramWEN   = xfer & grant_is_d & grant_wen;
    ramREN   = xfer & ~(grant_is_d & grant_wen);
    ramaddr  = xfer ? grant_addr  : '0;
    ramstore = xfer ? grant_store : '0;
    iwait    = '1;
    dwait    = '1;
    iload    = '0;
    dload    = '0;
    if (done) begin
      if (grant_is_d) begin
        dwait[grant_cpu] = 1'b0;
        dload[grant_cpu] = ramload;
      end else begin
        iwait[grant_cpu] = 1'b0;
        iload[grant_cpu] = ramload;
      end
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Bench for memory_arbiter: directed scenarios plus a randomized run against a transaction-level model.
module tb_memory_arbiter;
  import cpu_types_pkg::*;

  localparam int CPUS = 2;

  logic            CLK = 1'b0;
  logic            nRST;
  logic [CPUS-1:0] iREN, dREN, dWEN;
  word_t [CPUS-1:0] iaddr, daddr, dstore, iload, dload;
  logic [CPUS-1:0] iwait, dwait;
  logic            ramREN, ramWEN;
  word_t           ramaddr, ramstore;
  word_t           ramload  = '0;
  ramstate_t       ramstate = FREE;

  int n_cmp = 0;
  int n_bad = 0;

  memory_arbiter #(.CPUS(CPUS)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate)
  );

  always #5 CLK = ~CLK;

  // RAM model: lat-1 BUSY cycles, then err ERROR cycles, then ACCESS; unwritten words read as ~addr.
  word_t mem [word_t];
  int    ram_lat  = 1;
  int    ram_err  = 0;
  int    ram_cnt  = 0;
  bit    ram_rand = 1'b0;

  always begin
    @(posedge CLK);
    #1;
    if (ramREN || ramWEN) begin
      if (ram_cnt == 0 && ram_rand) begin
        ram_lat = $urandom_range(1, 3);
        ram_err = $urandom_range(0, 2);
      end
      ram_cnt++;
      ramload = mem.exists(ramaddr) ? mem[ramaddr] : ~ramaddr;
      if (ram_cnt < ram_lat) ramstate = BUSY;
      else if (ram_cnt < ram_lat + ram_err) ramstate = ERROR;
      else begin
        ramstate = ACCESS;
        ram_cnt  = 0;
        if (ramWEN) mem[ramaddr] = ramstore;
      end
    end else begin
      ram_cnt  = 0;
      ramstate = FREE;
      ramload  = '0;
    end
  end

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic test_reset();
    nRST = 1'b0; iREN = '0; dREN = '0; dWEN = '0;
    iaddr = '0; daddr = '0; dstore = '0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    n_cmp++; if (iwait !== '1 || dwait !== '1) begin n_bad++;
      $display("FAIL reset_waits: iwait=%b dwait=%b required 11/11", iwait, dwait); end
    n_cmp++; if (ramREN !== 1'b0 || ramWEN !== 1'b0) begin n_bad++;
      $display("FAIL reset_enables: ren=%b wen=%b required 0/0", ramREN, ramWEN); end
    n_cmp++; if (ramaddr !== '0 || ramstore !== '0) begin n_bad++;
      $display("FAIL reset_ram_bus: addr=%h store=%h required 0/0", ramaddr, ramstore); end
    n_cmp++; if (iload !== '0 || dload !== '0) begin n_bad++;
      $display("FAIL reset_loads: iload=%h dload=%h required 0", iload, dload); end
    tick();
    nRST = 1'b1;
  endtask

  task automatic test_single_fetch();
    mem[32'h100] = 32'hDEADBEEF;
    ram_lat = 2; ram_err = 0;
    tick(); iREN[0] = 1'b1; iaddr[0] = 32'h100;
    @(negedge CLK);
    n_cmp++; if (ramREN !== 1'b0 || iwait !== '1) begin n_bad++;
      $display("FAIL fetch_t0: ren=%b iwait=%b required 0/11", ramREN, iwait); end
    tick(); @(negedge CLK);
    n_cmp++; if (ramREN !== 1'b1 || ramWEN !== 1'b0 || ramaddr !== 32'h100 || iwait !== '1) begin n_bad++;
      $display("FAIL fetch_t1: ren=%b wen=%b addr=%h iwait=%b required 1/0/100/11", ramREN, ramWEN, ramaddr, iwait); end
    tick(); @(negedge CLK);
    n_cmp++; if (iwait !== 2'b10 || dwait !== '1) begin n_bad++;
      $display("FAIL fetch_t2_wait: iwait=%b dwait=%b required 10/11", iwait, dwait); end
    n_cmp++; if (iload[0] !== 32'hDEADBEEF || iload[1] !== '0 || dload !== '0) begin n_bad++;
      $display("FAIL fetch_t2_load: iload0=%h iload1=%h dload=%h required deadbeef/0/0", iload[0], iload[1], dload); end
    tick(); iREN[0] = 1'b0; @(negedge CLK);
    n_cmp++; if (iwait !== '1 || ramREN !== 1'b0 || iload !== '0) begin n_bad++;
      $display("FAIL fetch_t3: iwait=%b ren=%b iload=%h required 11/0/0", iwait, ramREN, iload); end
  endtask

  task automatic test_same_cpu_contention();
    ram_lat = 1; ram_err = 0;
    tick(); iREN[0] = 1'b1; iaddr[0] = 32'h0; dREN[0] = 1'b1; daddr[0] = 32'h400;
    tick(); @(negedge CLK);
    n_cmp++; if (ramaddr !== 32'h400 || ramREN !== 1'b1 || dwait !== 2'b10 || iwait !== '1) begin n_bad++;
      $display("FAIL contend_data: addr=%h ren=%b dwait=%b iwait=%b required 400/1/10/11", ramaddr, ramREN, dwait, iwait); end
    n_cmp++; if (dload[0] !== ~32'h400) begin n_bad++;
      $display("FAIL contend_dload: got %h required %h", dload[0], ~32'h400); end
    tick(); dREN[0] = 1'b0; @(negedge CLK);
    n_cmp++; if (ramREN !== 1'b0 || iwait !== '1 || dwait !== '1) begin n_bad++;
      $display("FAIL contend_idle: ren=%b iwait=%b dwait=%b required 0/11/11", ramREN, iwait, dwait); end
    tick(); @(negedge CLK);
    n_cmp++; if (ramaddr !== 32'h0 || iwait !== 2'b10 || iload[0] !== 32'hFFFF_FFFF) begin n_bad++;
      $display("FAIL contend_fetch: addr=%h iwait=%b iload0=%h required 0/10/ffffffff", ramaddr, iwait, iload[0]); end
    tick(); iREN[0] = 1'b0;
  endtask

  task automatic test_fairness();
    int seq[$];
    int cyc;
    cyc = 0;
    ram_lat = 1; ram_err = 0;
    tick(); daddr[0] = 32'h200; daddr[1] = 32'h300; dREN = '1;
    while (seq.size() < 8 && cyc < 40) begin
      @(negedge CLK);
      cyc++;
      for (int c = 0; c < CPUS; c++) begin
        if (dwait[c] === 1'b0) begin
          seq.push_back(c);
          n_cmp++; if (ramaddr !== daddr[c]) begin n_bad++;
            $display("FAIL fair_addr: cpu%0d addr=%h required %h", c, ramaddr, daddr[c]); end
        end
      end
      tick();
    end
    dREN = '0;
    n_cmp++; if (seq.size() != 8) begin n_bad++;
      $display("FAIL fair_count: got %0d grants required 8", seq.size()); end
    // The preceding contention scenario left CPU1 as the priority holder.
    for (int k = 0; k < seq.size(); k++) begin
      n_cmp++; if (seq[k] != (1 + k) % 2) begin n_bad++;
        $display("FAIL fair_order[%0d]: got cpu%0d required cpu%0d", k, seq[k], (1 + k) % 2); end
    end
  endtask

  task automatic test_store_error();
    ram_lat = 1; ram_err = 3;
    tick(); dWEN[1] = 1'b1; daddr[1] = 32'h20; dstore[1] = 32'h12345678;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (k == 1) dstore[1] = 32'hFFFF0000;
      @(negedge CLK);
      n_cmp++; if (ramWEN !== 1'b1 || ramREN !== 1'b0 || ramaddr !== 32'h20 || ramstore !== 32'h12345678) begin n_bad++;
        $display("FAIL store_bus[%0d]: wen=%b ren=%b addr=%h data=%h required 1/0/20/12345678", k, ramWEN, ramREN, ramaddr, ramstore); end
      n_cmp++; if (dwait[1] !== (k != 3) || dwait[0] !== 1'b1 || iwait !== '1) begin n_bad++;
        $display("FAIL store_wait[%0d]: dwait=%b iwait=%b required dwait1=%0d", k, dwait, iwait, (k != 3)); end
    end
    tick(); dWEN[1] = 1'b0; dstore[1] = '0;
    ram_err = 0;
    n_cmp++; if (!mem.exists(32'h20) || mem[32'h20] !== 32'h12345678) begin n_bad++;
      $display("FAIL store_mem: ram word 0x20 not 12345678"); end
  endtask

  task automatic test_abort();
    ram_lat = 10; ram_err = 0;
    tick(); dREN[0] = 1'b1; daddr[0] = 32'h40;
    tick(); @(negedge CLK);
    n_cmp++; if (ramREN !== 1'b1 || ramaddr !== 32'h40) begin n_bad++;
      $display("FAIL abort_start: ren=%b addr=%h required 1/40", ramREN, ramaddr); end
    tick(); dREN[0] = 1'b0; @(negedge CLK);
    n_cmp++; if (dwait !== '1) begin n_bad++;
      $display("FAIL abort_wait: dwait=%b required 11", dwait); end
    tick(); @(negedge CLK);
    n_cmp++; if (ramREN !== 1'b0 || ramWEN !== 1'b0 || dwait !== '1) begin n_bad++;
      $display("FAIL abort_idle: ren=%b wen=%b dwait=%b required 0/0/11", ramREN, ramWEN, dwait); end
    // Priority still with CPU0 after the abort, so CPU0 must win the tie.
    ram_lat = 1;
    dREN = '1; daddr[1] = 32'h44;
    tick(); @(negedge CLK);
    n_cmp++; if (ramaddr !== 32'h40 || dwait !== 2'b10) begin n_bad++;
      $display("FAIL abort_rr: addr=%h dwait=%b required 40/10", ramaddr, dwait); end
    tick(); dREN = '0;
  endtask

  task automatic test_async_reset();
    ram_lat = 10; ram_err = 0;
    tick(); iREN[1] = 1'b1; iaddr[1] = 32'h80;
    tick(); @(negedge CLK);
    n_cmp++; if (ramREN !== 1'b1 || ramaddr !== 32'h80) begin n_bad++;
      $display("FAIL areset_pre: ren=%b addr=%h required 1/80", ramREN, ramaddr); end
    #2 nRST = 1'b0;
    #1;
    n_cmp++; if (ramREN !== 1'b0 || ramWEN !== 1'b0 || ramaddr !== '0 || iwait !== '1 || dwait !== '1) begin n_bad++;
      $display("FAIL areset_now: ren=%b wen=%b addr=%h iwait=%b dwait=%b required 0/0/0/11/11", ramREN, ramWEN, ramaddr, iwait, dwait); end
    tick(); iREN[1] = 1'b0; nRST = 1'b1;
    tick(); @(negedge CLK);
    n_cmp++; if (ramREN !== 1'b0 || iwait !== '1) begin n_bad++;
      $display("FAIL areset_after: ren=%b iwait=%b required 0/11", ramREN, iwait); end
  endtask

  // Port p = 2*cpu + (1 for D-port): D before I inside a CPU, CPUs searched from rr upward.
  function automatic int pick(input bit [3:0] s, input int rr);
    for (int k = 0; k < CPUS; k++) begin
      int c;
      c = (rr + k) % CPUS;
      if (s[2*c+1]) return 2*c + 1;
      if (s[2*c]) return 2*c;
    end
    return -1;
  endfunction

  task automatic test_random();
    bit [3:0] act, done_q, wen_q, both_q, snap;
    word_t    addr_q [4];
    word_t    data_q [4];
    word_t    ref_mem [word_t];
    logic [CPUS-1:0] ew_i, ew_d;
    word_t [CPUS-1:0] el_i, el_d;
    int  rr_m, cur;
    bit  en, prev_en, prev_done, comp;
    act = '0; done_q = '0; wen_q = '0; both_q = '0; snap = '0;
    rr_m = 0; cur = -1; prev_en = 1'b0; prev_done = 1'b0;
    for (int p = 0; p < 4; p++) begin addr_q[p] = '0; data_q[p] = '0; end
    ram_rand = 1'b1;
    for (int cyc = 0; cyc < 400; cyc++) begin
      tick();
      for (int p = 0; p < 4; p++) begin
        if (done_q[p]) begin
          act[p] = 1'b0; done_q[p] = 1'b0;
        end else if (!act[p] && $urandom_range(0, 3) == 0) begin
          act[p]    = 1'b1;
          addr_q[p] = 32'h1000 + 4 * $urandom_range(0, 15);
          data_q[p] = $urandom;
          wen_q[p]  = (p % 2 == 1) && ($urandom_range(0, 1) == 1);
          both_q[p] = ($urandom_range(0, 1) == 1);
        end
      end
      for (int c = 0; c < CPUS; c++) begin
        iREN[c]   = act[2*c];
        iaddr[c]  = addr_q[2*c];
        dWEN[c]   = act[2*c+1] & wen_q[2*c+1];
        dREN[c]   = act[2*c+1] & (~wen_q[2*c+1] | both_q[2*c+1]);
        daddr[c]  = addr_q[2*c+1];
        dstore[c] = data_q[2*c+1];
      end
      @(negedge CLK);
      en = ramREN | ramWEN;
      n_cmp++; if (ramREN && ramWEN) begin n_bad++;
        $display("FAIL rnd_both_en: cycle %0d ren=1 wen=1 required not both", cyc); end
      if (en && !prev_en) cur = pick(snap, rr_m);
      if (en) begin
        n_cmp++;
        if (cur < 0) begin n_bad++;
          $display("FAIL rnd_grant: cycle %0d RAM driven with no pending request", cyc);
        end else if (ramaddr !== addr_q[cur] || ramWEN !== wen_q[cur] || (wen_q[cur] && ramstore !== data_q[cur])) begin n_bad++;
          $display("FAIL rnd_grant: cycle %0d addr=%h wen=%b data=%h required port%0d addr=%h wen=%b data=%h",
                   cyc, ramaddr, ramWEN, ramstore, cur, addr_q[cur], wen_q[cur], data_q[cur]);
        end
      end
      if (!en && !prev_en && snap != '0) begin n_cmp++; n_bad++;
        $display("FAIL rnd_no_grant: cycle %0d pending %b but RAM idle", cyc, snap); end
      if (prev_done) begin
        n_cmp++; if (en) begin n_bad++;
          $display("FAIL rnd_idle_gap: cycle %0d RAM driven right after completion, required idle", cyc); end
      end
      comp = en && (ramstate == ACCESS) && (cur >= 0);
      ew_i = '1; ew_d = '1; el_i = '0; el_d = '0;
      if (comp) begin
        if (cur % 2 == 1) begin
          ew_d[cur/2] = 1'b0;
          el_d[cur/2] = wen_q[cur] ? ramload
                        : (ref_mem.exists(addr_q[cur]) ? ref_mem[addr_q[cur]] : ~addr_q[cur]);
        end else begin
          ew_i[cur/2] = 1'b0;
          el_i[cur/2] = ref_mem.exists(addr_q[cur]) ? ref_mem[addr_q[cur]] : ~addr_q[cur];
        end
      end
      n_cmp++; if (iwait !== ew_i || dwait !== ew_d || iload !== el_i || dload !== el_d) begin n_bad++;
        $display("FAIL rnd_resp: cycle %0d iwait=%b dwait=%b iload=%h dload=%h required %b %b %h %h",
                 cyc, iwait, dwait, iload, dload, ew_i, ew_d, el_i, el_d); end
      if (comp) begin
        if (wen_q[cur]) ref_mem[addr_q[cur]] = data_q[cur];
        done_q[cur] = 1'b1;
        rr_m = (cur / 2 + 1) % CPUS;
      end
      prev_done = comp;
      prev_en   = en;
      snap      = act & ~done_q;
    end
    ram_rand = 1'b0;
    tick();
    iREN = '0; dREN = '0; dWEN = '0;
    repeat (12) tick();
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_same_cpu_contention();
    test_fairness();
    test_store_error();
    test_abort();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
